// File: rtl/mem_wb_load_ext.sv
// mem_wb_load_ext: MEM->WB pipeline register with load-data extraction.
// Captures the M-stage slot, then extracts, sign- or zero-extends and
// selects the writeback data from registered fields only. It also keeps a
// count of retired instructions.
// Optional feature: define LOAD_ALIGN_CHECK_EN to flag misaligned lw/lh/lhu
// in addr_err_W and suppress their register write. Without the macro,
// addr_err_W is tied to 0.
module mem_wb_load_ext (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_M,
  input  logic [2:0]  ltype_M,
  input  logic [31:0] dmdata_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] alu_M,
  input  logic        RegWrite_M,
  input  logic [4:0]  A3_M,
  input  logic [31:0] PC8_M,
  output logic [31:0] RD_W,
  output logic [4:0]  A3_W,
  output logic        RegWrite_W,
  output logic [31:0] PC8_W,
  output logic        valid_W,
  output logic        addr_err_W,
  output logic [31:0] retired_W
);

  localparam logic [2:0] LT_LW   = 3'd0;
  localparam logic [2:0] LT_LH   = 3'd1;
  localparam logic [2:0] LT_LHU  = 3'd2;
  localparam logic [2:0] LT_LB   = 3'd3;
  localparam logic [2:0] LT_LBU  = 3'd4;
  localparam logic [2:0] LT_RSV5 = 3'd5;
  localparam logic [2:0] LT_RSV6 = 3'd6;
  localparam logic [2:0] LT_NONE = 3'd7;

  logic        valid_q;
  logic [2:0]  ltype_q;
  logic [31:0] dmdata_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] alu_q;
  logic        regwrite_q;
  logic [4:0]  a3_q;
  logic [31:0] pc8_q;
  logic [31:0] retired_q;
  logic        addr_err;

  // Only the byte offset of the address matters once the word is read.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_M[31:2];

  // W-stage register bank: reset > flush > stall > capture.
  // NOTE: sequential state uses non-blocking (<=) so that every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q    <= 1'b0;
      ltype_q    <= LT_NONE;
      dmdata_q   <= 32'd0;
      addr_lo_q  <= 2'd0;
      alu_q      <= 32'd0;
      regwrite_q <= 1'b0;
      a3_q       <= 5'd0;
      pc8_q      <= 32'd0;
    end else if (!stall) begin
      valid_q    <= valid_M;
      ltype_q    <= ltype_M;
      dmdata_q   <= dmdata_M;
      addr_lo_q  <= addr_M[1:0];
      alu_q      <= alu_M;
      regwrite_q <= RegWrite_M;
      a3_q       <= A3_M;
      pc8_q      <= PC8_M;
    end
  end

  // Retired counter: counts real instructions captured into W and wraps.
  // A flush leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'd0;
    end else if (!flush && !stall && valid_M) begin
      retired_q <= retired_q + 32'd1;
    end
  end

`ifdef LOAD_ALIGN_CHECK_EN
  logic misalign_M;
  logic addr_err_q;

  // Misalignment detect on the incoming slot: lw needs offset 0, and
  // lh/lhu need an even offset.
  always_comb begin
    misalign_M = 1'b0;
    if (valid_M) begin
      if (ltype_M == LT_LW) begin
        misalign_M = (addr_M[1:0] != 2'd0);
      end else if (ltype_M == LT_LH || ltype_M == LT_LHU) begin
        misalign_M = addr_M[0];
      end
    end
  end

  // Registered error flag, following the same priority as the W bank.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      addr_err_q <= 1'b0;
    end else if (!stall) begin
      addr_err_q <= misalign_M;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign addr_err = 1'b0;
`endif

  // Load extraction from registered fields only. No M-stage input reaches
  // an output combinationally.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_sel;
    half     = addr_lo_q[1] ? dmdata_q[31:16] : dmdata_q[15:0];
    byte_sel = dmdata_q[7:0];
    case (addr_lo_q)
      2'd0: byte_sel = dmdata_q[7:0];
      2'd1: byte_sel = dmdata_q[15:8];
      2'd2: byte_sel = dmdata_q[23:16];
      2'd3: byte_sel = dmdata_q[31:24];
      default: byte_sel = dmdata_q[7:0];
    endcase
    RD_W = alu_q;
    case (ltype_q)
      LT_LW:   RD_W = dmdata_q;
      LT_LH:   RD_W = {{16{half[15]}}, half};
      LT_LHU:  RD_W = {16'd0, half};
      LT_LB:   RD_W = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  RD_W = {24'd0, byte_sel};
      LT_RSV5: RD_W = dmdata_q;
      LT_RSV6: RD_W = dmdata_q;
      default: RD_W = alu_q;
    endcase
  end

  // Reserved load types never write the register file.
  assign RegWrite_W = regwrite_q && valid_q && !addr_err &&
                      (ltype_q != LT_RSV5) && (ltype_q != LT_RSV6);
  assign A3_W       = a3_q;
  assign PC8_W      = pc8_q;
  assign valid_W    = valid_q;
  assign addr_err_W = addr_err;
  assign retired_W  = retired_q;

endmodule

// File: tb/tb_mem_wb_load_ext.sv
// Testbench for mem_wb_load_ext: directed cases plus randomized traffic.
// A behavioural slot model predicts every output after each edge.
module tb_mem_wb_load_ext;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_M, RegWrite_M;
  logic [2:0]  ltype_M;
  logic [31:0] dmdata_M, addr_M, alu_M, PC8_M;
  logic [4:0]  A3_M;
  logic [31:0] RD_W, PC8_W, retired_W;
  logic [4:0]  A3_W;
  logic        RegWrite_W, valid_W, addr_err_W;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_wb_load_ext dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_M(valid_M), .ltype_M(ltype_M), .dmdata_M(dmdata_M),
    .addr_M(addr_M), .alu_M(alu_M), .RegWrite_M(RegWrite_M),
    .A3_M(A3_M), .PC8_M(PC8_M),
    .RD_W(RD_W), .A3_W(A3_W), .RegWrite_W(RegWrite_W), .PC8_W(PC8_W),
    .valid_W(valid_W), .addr_err_W(addr_err_W), .retired_W(retired_W)
  );

  // Reference model: the instruction sitting in W, as plain values.
  typedef struct {
    bit          valid;
    int unsigned ltype;
    bit [31:0]   data;
    int unsigned addr;
    bit [31:0]   alu;
    bit          rw;
    bit [4:0]    a3;
    bit [31:0]   pc8;
  } slot_t;

  slot_t     m_slot;
  bit [31:0] m_retired;

  function automatic slot_t bubble();
    slot_t s;
    s.valid = 0; s.ltype = 7; s.data = 0; s.addr = 0;
    s.alu = 0; s.rw = 0; s.a3 = 0; s.pc8 = 0;
    return s;
  endfunction

  function automatic bit model_err(slot_t s);
`ifdef LOAD_ALIGN_CHECK_EN
    if (!s.valid) return 0;
    if (s.ltype == 0) return (s.addr % 4) != 0;
    if (s.ltype == 1 || s.ltype == 2) return (s.addr % 2) != 0;
    return 0;
`else
    return s.valid && 1'b0;
`endif
  endfunction

  function automatic bit [31:0] model_rd(slot_t s);
    int unsigned h, b;
    int          sh, sb;
    h = (s.data >> (16 * ((s.addr / 2) % 2))) & 32'hFFFF;
    b = (s.data >> (8 * (s.addr % 4))) & 32'hFF;
    sh = (h >= 32768) ? int'(h) - 65536 : int'(h);
    sb = (b >= 128) ? int'(b) - 256 : int'(b);
    case (s.ltype)
      0, 5, 6: return s.data;
      1: return 32'(sh);
      2: return 32'(h);
      3: return 32'(sb);
      4: return 32'(b);
      default: return s.alu;
    endcase
  endfunction

  function automatic bit model_we(slot_t s);
    return s.rw && s.valid && !model_err(s) && s.ltype != 5 && s.ltype != 6;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".RD_W"}, RD_W, model_rd(m_slot));
    check({tag, ".A3_W"}, {27'd0, A3_W}, {27'd0, m_slot.a3});
    check({tag, ".RegWrite_W"}, {31'd0, RegWrite_W}, {31'd0, model_we(m_slot)});
    check({tag, ".PC8_W"}, PC8_W, m_slot.pc8);
    check({tag, ".valid_W"}, {31'd0, valid_W}, {31'd0, m_slot.valid});
    check({tag, ".addr_err_W"}, {31'd0, addr_err_W}, {31'd0, model_err(m_slot)});
    check({tag, ".retired_W"}, retired_W, m_retired);
  endtask

  // Advance one edge: update the model from the current inputs, then compare.
  task automatic tick(input string tag);
    slot_t nxt;
    nxt.valid = valid_M; nxt.ltype = ltype_M; nxt.data = dmdata_M;
    nxt.addr = addr_M % 4; nxt.alu = alu_M; nxt.rw = RegWrite_M;
    nxt.a3 = A3_M; nxt.pc8 = PC8_M;
    if (reset) begin
      m_slot = bubble(); m_retired = 0;
    end else if (flush) begin
      m_slot = bubble();
    end else if (!stall) begin
      m_slot = nxt;
      if (valid_M) m_retired = m_retired + 1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit [2:0] lt, input bit [31:0] d,
                       input bit [31:0] a, input bit rw);
    valid_M = v; ltype_M = lt; dmdata_M = d; addr_M = a; RegWrite_M = rw;
    alu_M = $urandom; A3_M = 5'($urandom); PC8_M = $urandom;
  endtask

  initial begin
    m_slot = bubble(); m_retired = 0;
    reset = 1; stall = 0; flush = 0;
    drive(1, 0, 32'hDEADBEEF, 32'h0, 1);
    tick("reset0");
    tick("reset1");
    check("reset.RD_zero", RD_W, 32'd0);
    reset = 0;

    // lb from the top byte: sign-extends 0x80.
    drive(1, 3, 32'h80ABCD12, 32'h00001003, 1);
    tick("lb_neg");
    check("lb_neg.const", RD_W, 32'hFFFFFF80);
    check("lb_neg.we", {31'd0, RegWrite_W}, 32'd1);

    drive(1, 2, 32'h92345678, 32'h00002002, 1);
    tick("lhu_hi");
    check("lhu_hi.const", RD_W, 32'h00009234);
    drive(1, 1, 32'h92345678, 32'h00002002, 1);
    tick("lh_hi");
    check("lh_hi.const", RD_W, 32'hFFFF9234);

    // lw captured, then held for three stalled edges with new M inputs.
    drive(1, 0, 32'h12345678, 32'h00000100, 1);
    tick("lw_cap");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1);
      tick("stall_hold");
      check("stall_hold.const", RD_W, 32'h12345678);
    end

    // Flush and stall together: bubble, count unchanged.
    flush = 1;
    drive(1, 0, 32'hCAFEF00D, 32'h0, 1);
    tick("flush_stall");
    check("flush_stall.valid", {31'd0, valid_W}, 32'd0);
    flush = 0; stall = 0;

    // Misaligned lw at offset 2.
    drive(1, 0, 32'hA5A5_5A5A, 32'h00000006, 1);
    tick("lw_misalign");
`ifdef LOAD_ALIGN_CHECK_EN
    check("lw_misalign.err", {31'd0, addr_err_W}, 32'd1);
    check("lw_misalign.we", {31'd0, RegWrite_W}, 32'd0);
`else
    check("lw_misalign.err", {31'd0, addr_err_W}, 32'd0);
    check("lw_misalign.rd", RD_W, 32'hA5A55A5A);
`endif

    // Reserved load types return dmdata and never write the register file.
    drive(1, 5, 32'h0BADF00D, 32'h1, 1);
    tick("rsv5");
    drive(1, 7, 32'h0, 32'h3, 1);
    tick("non_load");

    // Randomized traffic with occasional stall and flush.
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom));
      tick("rand");
    end
    stall = 0; flush = 0;

    // Counter wrap: preload the all-ones count, then one valid capture.
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFFFFFF;
    check("wrap.pre", retired_W, 32'hFFFFFFFF);
    drive(1, 4, 32'h000000F0, 32'h0, 1);
    tick("wrap");
    check("wrap.zero", retired_W, 32'd0);

    // A valid writing load in W, then a reset with a new valid slot.
    drive(1, 0, 32'h11112222, 32'h0, 1);
    tick("pre_reset");
    reset = 1;
    drive(1, 0, 32'h33334444, 32'h0, 1);
    tick("mid_reset");
    check("mid_reset.we", {31'd0, RegWrite_W}, 32'd0);
    check("mid_reset.rd", RD_W, 32'd0);
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_load_ext.md
MEM_WB_LOAD_EXT -- requirements
Module: mem_wb_load_ext

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold all W-stage registers
flush  in  1  insert bubble into W stage
valid_M  in  1  M-stage slot holds a real instruction
ltype_M  in  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu, 7=non-load, 5/6=reserved
dmdata_M  in  32  word read from data memory at addr_M[13:2]
addr_M  in  32  effective byte address
alu_M  in  32  ALU result for non-load writeback
RegWrite_M  in  1  instruction writes the register file
A3_M  in  5  destination register
PC8_M  in  32  PC+8 of the M-stage instruction
RD_W  out  32  extended writeback data
A3_W  out  5  destination register
RegWrite_W  out  1  effective register-file write enable
PC8_W  out  32  PC+8 of the W-stage instruction
valid_W  out  1  W slot holds a real instruction
addr_err_W  out  1  misaligned-load flag
retired_W  out  32  count of instructions captured into W
REQ-002 Reset SHALL be named reset, synchronous, active-high; clock SHALL be named clk.

Function
REQ-003 Captured fields: valid, ltype, dmdata, addr[1:0], alu, RegWrite, A3, PC8; one-cycle latency M->W.
REQ-004 Per edge, priority reset > flush > stall > capture.
REQ-005 Flush SHALL load a bubble: valid_W=0, RegWrite_W=0, A3_W=0, PC8_W=0, ltype=7, data fields 0.
REQ-006 Stall without flush SHALL hold every W register unchanged, including retired_W.
REQ-007 RD_W SHALL be combinational from registered fields only; no combinational path from any M input to any output.
REQ-008 lw: RD_W = dmdata.
REQ-009 lh/lhu: half = addr[1] ? dmdata[31:16] : dmdata[15:0]; lh sign-extends, lhu zero-extends.
REQ-010 lb/lbu: byte = dmdata[8*addr[1:0]+7 : 8*addr[1:0]]; lb sign-extends, lbu zero-extends.
REQ-011 ltype 7: RD_W = alu; ltype 5/6: RD_W = dmdata, RegWrite_W forced 0.
REQ-012 RegWrite_W = registered RegWrite AND valid_W AND NOT addr_err_W AND ltype not 5/6.
REQ-013 retired_W SHALL increment by 1 on each capture edge with valid_M=1; wraps 0xFFFFFFFF -> 0x00000000.
REQ-014 Flush and stall together: flush wins; retired_W unchanged.

Reset
REQ-015 On reset edge all outputs SHALL be 0: RD_W=0 (ltype=7, alu=0), A3_W=0, RegWrite_W=0, PC8_W=0, valid_W=0, addr_err_W=0, retired_W=0.
REQ-016 Reset asserted mid-stream SHALL discard the W-stage instruction; no write-enable pulse on that edge's output.

Configuration
REQ-017 Macro LOAD_ALIGN_CHECK_EN, when defined, SHALL set addr_err_W=1 for valid lw with addr[1:0]!=0 or lh/lhu with addr[0]=1; flag registered, cleared by flush/reset, held by stall.
REQ-018 Without LOAD_ALIGN_CHECK_EN, addr_err_W SHALL be constant 0; misaligned lw returns dmdata unchanged, lh/lhu use addr[1] only.

Verification
REQ-019 lb, addr=0x0000_1003, dmdata=0x80AB_CD12, RegWrite_M=1 -> next cycle RD_W=0xFFFF_FF80, RegWrite_W=1.
REQ-020 lhu, addr=0x0000_2002, dmdata=0x9234_5678 -> RD_W=0x0000_9234; lh same inputs -> RD_W=0xFFFF_9234.
REQ-021 Capture lw (dmdata=0x1234_5678), then stall=1 for 3 cycles with new M inputs -> RD_W stays 0x1234_5678, retired_W unchanged.
REQ-022 stall=1 and flush=1 same edge with valid_M=1 -> valid_W=0, RegWrite_W=0, retired_W unchanged.
REQ-023 LOAD_ALIGN_CHECK_EN defined, lw addr=0x0000_0006 -> addr_err_W=1, RegWrite_W=0; undefined -> addr_err_W=0, RegWrite_W=1, RD_W=dmdata.
REQ-024 Preload retired_W=0xFFFF_FFFF via 2^32-1 captures or forced state, one more valid capture -> retired_W=0x0000_0000; reset asserted -> all outputs 0 next edge.
